// File: rtl/arm_cond_unit.sv
// ARM condition unit: architectural NZCV register, condition-field evaluation,
// the latched condition-pass bit, and gating of the controller write strobes.
module arm_cond_unit #(
  parameter int FLAG_W  = 4,
  parameter bit NV_EXEC = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic              flag_valid,
  input  logic [1:0]        FlagW,
  input  logic              latch_cond,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NextPC,
  output logic [FLAG_W-1:0] Flags,
  output logic              carry,
  output logic              CondEx,
  output logic              CondExQ,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite
);

  function automatic logic cond_pass(input logic [3:0] c, input logic [FLAG_W-1:0] f);
    logic n, z, cf, v;
    logic res;
    n   = f[3];
    z   = f[2];
    cf  = f[1];
    v   = f[0];
    res = 1'b0;
    unique case (c)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = cf;
      4'b0011: res = !cf;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = cf & !z;
      4'b1001: res = !cf | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = NV_EXEC;
    endcase
    return res;
  endfunction

  assign CondEx = cond_pass(Cond, Flags);
  assign carry  = Flags[1];

  // Condition-pass latch: sampled in decode, held for the rest of the instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      CondExQ <= 1'b0;
    end else if (latch_cond) begin
      CondExQ <= CondEx;
    end
  end

  // Flag register: NZ and CV halves written independently, gated by the held pass bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags <= '0;
    end else if (flag_valid && CondExQ) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign PCWrite  = (PCS & CondExQ) | NextPC;
  assign RegWrite = RegW & CondExQ;
  assign MemWrite = MemW & CondExQ;

endmodule

// File: tb/tb_arm_cond_unit.sv
// Bench for arm_cond_unit: directed scenarios plus randomized cycles
// checked against a behavioural model of the flag register and condition rules.
module tb_arm_cond_unit;
  localparam int FLAG_W  = 4;
  localparam bit NV_EXEC = 1'b0;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        Cond;
  logic [FLAG_W-1:0] ALUFlags;
  logic              flag_valid;
  logic [1:0]        FlagW;
  logic              latch_cond, PCS, RegW, MemW, NextPC;
  logic [FLAG_W-1:0] Flags;
  logic              carry, CondEx, CondExQ, PCWrite, RegWrite, MemWrite;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] m_flags;
  logic       m_q;

  arm_cond_unit #(.FLAG_W(FLAG_W), .NV_EXEC(NV_EXEC)) dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .ALUFlags(ALUFlags),
    .flag_valid(flag_valid), .FlagW(FlagW), .latch_cond(latch_cond),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NextPC(NextPC),
    .Flags(Flags), .carry(carry), .CondEx(CondEx), .CondExQ(CondExQ),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
  );

  always #5 clk = ~clk;

  // Conditions come in complementary pairs: bit 0 inverts the base predicate of Cond[3:1].
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, p;
    {n, z, cf, v} = f;
    if (c == 4'hF) return NV_EXEC;
    case (c[3:1])
      3'd0:    p = z;
      3'd1:    p = cf;
      3'd2:    p = n;
      3'd3:    p = v;
      3'd4:    p = cf & ~z;
      3'd5:    p = (n == v);
      3'd6:    p = ~z & (n == v);
      default: p = 1'b1;
    endcase
    return p ^ c[0];
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    logic [3:0] mask, nf;
    logic       nq;
    mask = {{2{FlagW[1]}}, {2{FlagW[0]}}};
    nf   = (flag_valid && m_q) ? ((m_flags & ~mask) | (ALUFlags & mask)) : m_flags;
    nq   = latch_cond ? ref_cond(Cond, m_flags) : m_q;
    @(posedge clk);
    m_flags = nf;
    m_q     = nq;
    #1;
  endtask

  task automatic idle_inputs();
    Cond = 4'hE; ALUFlags = '0; flag_valid = 0; FlagW = 2'b00; latch_cond = 0;
    PCS = 0; RegW = 0; MemW = 0; NextPC = 0;
  endtask

  // Latch AL then write all four flags, leaving CondExQ=1 and Flags=f.
  task automatic set_flags(input logic [3:0] f);
    idle_inputs();
    Cond = 4'hE; latch_cond = 1; tick();
    latch_cond = 0; flag_valid = 1; FlagW = 2'b11; ALUFlags = f; tick();
    flag_valid = 0; FlagW = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0; PCS = 1; RegW = 1; MemW = 1; NextPC = 0;
    m_flags = '0; m_q = 0;
    #2;
    n_cmp++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", Flags); end
    n_cmp++; if (CondExQ !== 1'b0) begin n_fail++; $display("FAIL reset_condexq: got %b exp 0", CondExQ); end
    n_cmp++; if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b exp 000", {PCWrite, RegWrite, MemWrite}); end
    NextPC = 1; #1;
    n_cmp++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL reset_nextpc: got %b exp 1", PCWrite); end
    NextPC = 0;
    @(posedge clk); #1;
    reset_n = 1;
    flag_valid = 1; FlagW = 2'b11; ALUFlags = 4'hF;
    tick(); tick();
    n_cmp++; if (Flags !== 4'b0000 || carry !== 1'b0) begin n_fail++; $display("FAIL post_reset_hold: got %b/%b exp 0000/0", Flags, carry); end
    n_cmp++; if ({CondExQ, RegWrite, MemWrite} !== 3'b000) begin n_fail++; $display("FAIL post_reset_q: got %b exp 000", {CondExQ, RegWrite, MemWrite}); end
    idle_inputs();
  endtask

  task automatic test_flag_write();
    idle_inputs();
    Cond = 4'hE; latch_cond = 1; tick();
    n_cmp++; if (CondExQ !== 1'b1) begin n_fail++; $display("FAIL fw_latch: got %b exp 1", CondExQ); end
    latch_cond = 0; flag_valid = 1; FlagW = 2'b11; ALUFlags = 4'b1010;
    #1;
    n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL fw_no_bypass: got %b exp 0", carry); end
    tick();
    n_cmp++; if (Flags !== 4'b1010 || carry !== 1'b1) begin n_fail++; $display("FAIL fw_both: got %b/%b exp 1010/1", Flags, carry); end
    idle_inputs();
  endtask

  task automatic test_partial_write();
    set_flags(4'b0110);
    flag_valid = 1; FlagW = 2'b10; ALUFlags = 4'b1001; tick();
    n_cmp++; if (Flags !== 4'b1010) begin n_fail++; $display("FAIL partial_nz: got %b exp 1010", Flags); end
    FlagW = 2'b01; ALUFlags = 4'b0101; tick();
    n_cmp++; if (Flags !== 4'b1001) begin n_fail++; $display("FAIL partial_cv: got %b exp 1001", Flags); end
    FlagW = 2'b00; ALUFlags = 4'b0000; tick();
    n_cmp++; if (Flags !== 4'b1001) begin n_fail++; $display("FAIL partial_none: got %b exp 1001", Flags); end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    logic [3:0] fl [6];
    fl = '{4'b0000, 4'b0100, 4'b0010, 4'b1000, 4'b1001, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      set_flags(fl[i]);
      for (int c = 0; c < 16; c++) begin
        Cond = c[3:0]; #1;
        n_cmp++;
        if (CondEx !== ref_cond(c[3:0], fl[i])) begin
          n_fail++; $display("FAIL sweep flags=%b cond=%b: got %b exp %b", fl[i], c[3:0], CondEx, ref_cond(c[3:0], fl[i]));
        end
      end
    end
    Cond = 4'hF; #1;
    n_cmp++; if (CondEx !== 1'b0) begin n_fail++; $display("FAIL sweep_nv: got %b exp 0", CondEx); end
    idle_inputs();
  endtask

  task automatic test_failed_cond();
    set_flags(4'b0000);
    Cond = 4'b0000; latch_cond = 1; tick();
    latch_cond = 0; RegW = 1; MemW = 1; PCS = 1; NextPC = 0;
    flag_valid = 1; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    n_cmp++; if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin n_fail++; $display("FAIL failed_strobes: got %b exp 000", {PCWrite, RegWrite, MemWrite}); end
    tick();
    n_cmp++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL failed_flags: got %b exp 0000", Flags); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    set_flags(4'b0000);
    Cond = 4'b0000; latch_cond = 1; flag_valid = 1; FlagW = 2'b10; ALUFlags = 4'b0100;
    tick();
    n_cmp++; if (Flags !== 4'b0100) begin n_fail++; $display("FAIL simul_flags: got %b exp 0100", Flags); end
    n_cmp++; if (CondExQ !== 1'b0) begin n_fail++; $display("FAIL simul_condexq: got %b exp 0", CondExQ); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    set_flags(4'b1111);
    RegW = 1; MemW = 1; PCS = 1; #1;
    n_cmp++; if ({PCWrite, RegWrite, MemWrite} !== 3'b111) begin n_fail++; $display("FAIL async_pre: got %b exp 111", {PCWrite, RegWrite, MemWrite}); end
    #1 reset_n = 0; #1;
    m_flags = '0; m_q = 0;
    n_cmp++; if ({CondExQ, PCWrite, RegWrite, MemWrite} !== 4'b0000 || Flags !== 4'b0000) begin
      n_fail++; $display("FAIL async_clear: got q/strb=%b flags=%b exp 0000/0000", {CondExQ, PCWrite, RegWrite, MemWrite}, Flags);
    end
    #1 reset_n = 1;
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'($urandom);
      flag_valid = 1'($urandom); latch_cond = ($urandom_range(0, 3) == 0);
      PCS = 1'($urandom); RegW = 1'($urandom); MemW = 1'($urandom); NextPC = 1'($urandom);
      #1;
      n_cmp++; if (CondEx !== ref_cond(Cond, m_flags)) begin n_fail++; $display("FAIL rnd_condex %0d: got %b exp %b", i, CondEx, ref_cond(Cond, m_flags)); end
      n_cmp++; if ({PCWrite, RegWrite, MemWrite} !== {(PCS & m_q) | NextPC, RegW & m_q, MemW & m_q}) begin
        n_fail++; $display("FAIL rnd_strobes %0d: got %b exp %b", i, {PCWrite, RegWrite, MemWrite}, {(PCS & m_q) | NextPC, RegW & m_q, MemW & m_q});
      end
      tick();
      n_cmp++; if (Flags !== m_flags || carry !== m_flags[1]) begin n_fail++; $display("FAIL rnd_flags %0d: got %b/%b exp %b/%b", i, Flags, carry, m_flags, m_flags[1]); end
      n_cmp++; if (CondExQ !== m_q) begin n_fail++; $display("FAIL rnd_condexq %0d: got %b exp %b", i, CondExQ, m_q); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_flag_write();
    test_partial_write();
    test_cond_sweep();
    test_failed_cond();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/arm_cond_unit.md
Name: arm_cond_unit

Overview:
Consumer side of the ALU flag interface for the multicycle ARM core. Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it. It latches the condition-pass result for the rest of the instruction and gates the controller's PC, register, memory and flag write strobes. It also returns the registered C flag to the ALU carry input for ADC/SBC/RSC.

Parameters:
FLAG_W, 4, width of the flag vector {N,Z,C,V}; fixed at 4, exists only for bench readability.
NV_EXEC, 0, result of condition 4'b1111: 0 = never execute (ARMv4 NV), 1 = treat as AL.

Ports:
clk  input  1  core clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
Cond  input  4  instruction condition field Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from ALU, valid when flag_valid=1
flag_valid  input  1  ALU result/flags valid this cycle (controller ALU-writeback states)
FlagW  input  2  [1]=write N,Z; [0]=write C,V (from decoder)
latch_cond  input  1  controller decode state: capture condition result
PCS  input  1  instruction writes PC (branch or Rd=R15)
RegW  input  1  unconditional register-write request from controller FSM
MemW  input  1  unconditional memory-write request from controller FSM
NextPC  input  1  sequential PC increment (fetch state), never gated
Flags  output  4  current registered {N,Z,C,V}
carry  output  1  registered C, drives ALU carry input
CondEx  output  1  combinational condition result from Cond and Flags
CondExQ  output  1  registered CondEx, held until next latch_cond
PCWrite  output  1  (PCS & CondExQ) | NextPC
RegWrite  output  1  RegW & CondExQ
MemWrite  output  1  MemW & CondExQ

Behaviour:
- Reset (reset_n=0, async): Flags=4'b0000, carry=0, CondExQ=0. Hence RegWrite=MemWrite=0, and PCWrite=NextPC.
- Condition decode, combinational on Flags:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1.
  - 1111 = NV_EXEC.
- CondExQ: on a rising edge with latch_cond=1, CondExQ <= CondEx (evaluated from pre-edge Flags); otherwise it holds. Latency 1 cycle.
- Flag register update at a rising edge, only when flag_valid=1 and CondExQ=1 (pre-edge value):
  - FlagW[1]: N,Z <= ALUFlags[3:2].
  - FlagW[0]: C,V <= ALUFlags[1:0].
  - The two halves are independent, so logical ops update NZ only.
- FlagW or flag_valid alone never writes; a failed condition never writes.
- Simultaneous latch_cond and flag write in the same cycle:
  - The write is gated by the old CondExQ.
  - The new CondExQ is computed from the old Flags, not the incoming ALUFlags.
- carry always equals Flags[1]. A write to C becomes visible to the ALU the cycle after the update edge; there is no bypass.
- PCWrite/RegWrite/MemWrite are combinational from inputs and CondExQ; there is no added latency.
- No X propagation: the condition decode is fully specified for all 16 codes.
- Reset asserted mid-instruction clears CondExQ immediately. Any pending gated write is suppressed asynchronously.

Test Plan:
- Reset: hold reset_n=0 with PCS=RegW=MemW=1, NextPC=0 -> Flags=0000, CondExQ=0, PCWrite=RegWrite=MemWrite=0; release -> unchanged until latch_cond.
- Flag write, both halves: Cond=1110, latch_cond pulse, then flag_valid=1, FlagW=11, ALUFlags=1010 -> next cycle Flags=1010, carry=1.
- Partial write: Flags=0110, FlagW=10, ALUFlags=1001 -> Flags=1010 (CV preserved).
- Condition sweep: for each Flags in {0000,0100,0010,1000,1001,0001} and all 16 Cond values -> CondEx matches the decode table; Cond=1111 gives 0 with NV_EXEC=0.
- Failed condition: Flags=0000, Cond=0000 (EQ), latch_cond, then RegW=MemW=PCS=1, flag_valid=1, FlagW=11, ALUFlags=0100 -> RegWrite=MemWrite=PCWrite=0, Flags stay 0000.
- Simultaneous: CondExQ=1, Flags=0000, Cond=0000, latch_cond=1 with flag_valid=1, FlagW=10, ALUFlags=0100 -> Flags=0100, CondExQ=0 (evaluated on old Z=0).
